sc_stream_gen: RTL and testbench
================================

Name: sc_stream_gen

Overview:
- Downstream consumer of the FIR input delay line.
- Converts every tap (sfix8_En7) into a bipolar stochastic bitstream, one bit per tap per clock, over a window of 2^WIDTH cycles.
- All taps are compared against one shared, full-period random sequence.
- Paces the delay line by issuing a one-cycle advance pulse (wired to the delay line's clk_enable) at the end of each window, so tap values stay constant for a whole window.

Parameters:
- NTAPS, 152, number of taps consumed.
- WIDTH, 8, tap width in bits; window length is 2^WIDTH cycles.
- LFSR_POLY, 8'hB8, Fibonacci feedback mask (x^8+x^6+x^5+x^4+1).
- LFSR_SEED, 8'h01, RNG value loaded on reset and on IDLE->RUN.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- en  in  1  run request.
- taps_flat  in  NTAPS*WIDTH  signed taps, tap i in bits [i*WIDTH+WIDTH-1 : i*WIDTH], tap 0 = newest.
- sample_advance  out  1  one-cycle pulse that shifts the delay line.
- stream_out  out  NTAPS  stochastic bit per tap.
- stream_valid  out  1  stream_out carries a valid bit.
- window_last  out  1  stream_out carries the last bit of a window.
- busy  out  1  state == RUN.

Behaviour:
- Reset values: all outputs 0; state IDLE; cnt 0; rng = LFSR_SEED.
- FSM states: IDLE, RUN.
- IDLE -> RUN on en=1. On that transition: cnt <= 0, rng <= LFSR_SEED.
- RUN, each cycle:
  - cnt <= cnt+1, wrapping at 2^WIDTH.
  - rng <= next(rng).
  - Offset value u_i = tap_i XOR (1 << (WIDTH-1)), i.e. tap+2^(WIDTH-1), unsigned.
  - Raw bit_i = (u_i > rng), unsigned compare.
- RNG next state (de Bruijn extended LFSR, period exactly 2^WIDTH, includes 0):
  - fb = ^(rng & LFSR_POLY) XOR (rng[WIDTH-2:0] == 0).
  - next = {rng[WIDTH-2:0], fb}.
- sample_advance: flop-driven; high exactly during each RUN cycle with cnt == 2^WIDTH-1; never high in IDLE.
  - The delay line shifts at the edge ending that cycle.
  - taps_flat is therefore constant for cnt = 0..2^WIDTH-1 of the following window.
- Output latency 1 cycle, all outputs registered:
  - stream_out <= raw bits.
  - stream_valid <= (state == RUN).
  - window_last <= (RUN && cnt == 2^WIDTH-1).
- Window exactness: because rng visits each value 0..2^WIDTH-1 exactly once per window, ones count on stream_out[i] per window = u_i exactly.
  - Range is 0 for tap -128 up to 255 for tap +127.
  - Decoded bipolar value (2*ones/256 - 1) equals tap/128 exactly.
- en deasserted in RUN: the current window completes, including its sample_advance. At the window end, if en=0, go to IDLE; otherwise start the next window without a gap.
- en toggled during a window has no effect until the window boundary.
- stream_out holds its last value when stream_valid=0; consumers ignore it.
- Reset asserted mid-window: immediate return to reset values; the partial window is discarded and no sample_advance is issued.
- There is no back-pressure; the consumer accepts one bit per tap per cycle while stream_valid=1.

Test Plan:
- RNG period: hold en=1 and log rng over 256 cycles -> all 256 values appear exactly once; the sequence repeats identically in the next window; seed is 8'h01 at cnt=0.
- Exact encoding: taps = {-128, -1, 0, 64, 127, rest 0}, one window -> ones counts on stream_out[0..4] = 0, 127, 128, 192, 255; untouched taps give 128.
- Pacing: en=1 for 3 windows -> sample_advance pulses at cycles 255, 511, 767 after entry to RUN, each 1 cycle wide; window_last is 1 cycle later each time; stream_valid stays continuously 1.
- Graceful stop: drop en at cnt=100 -> the window completes with sample_advance at cnt=255, then IDLE; stream_valid falls 1 cycle after the last bit; busy=0.
- Reset mid-window: assert reset at cnt=50 -> all outputs 0 immediately, state IDLE, no advance pulse. Re-enable -> rng restarts at 8'h01 and the counts match the encoding test.
- End-to-end with the delay line: feed samples 0x40, 0xC0 on successive advances -> window after the 1st advance: tap0 count 192; after the 2nd: tap0 count 64, tap1 count 192.

Source files
------------

// File: rtl/sc_stream_gen.sv
// sc_stream_gen: turns every FIR delay-line tap (sfix8_En7) into a bipolar
// stochastic bitstream over a window of 2^WIDTH cycles, all taps compared
// against one shared full-period random sequence, and paces the delay line
// with one advance pulse per window.
module sc_stream_gen #(
  parameter int                 NTAPS     = 152,
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   LFSR_POLY = 8'hB8,
  parameter logic [WIDTH-1:0]   LFSR_SEED = 8'h01
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NTAPS*WIDTH-1:0] taps_flat,
  output logic                   sample_advance,
  output logic [NTAPS-1:0]       stream_out,
  output logic                   stream_valid,
  output logic                   window_last,
  output logic                   busy
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       RUN     = 1'b1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] OFFSET  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rng_q, rng_d;
  logic             adv_q, adv_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [NTAPS-1:0] stream_q, stream_d;

  logic [WIDTH-1:0] rng_next;
  logic             fb;
  logic [NTAPS-1:0] raw;

  // de Bruijn extended LFSR: the zero-detect term splices 0 into the cycle
  always_comb begin
    fb       = (^(rng_q & LFSR_POLY)) ^ (rng_q[WIDTH-2:0] == '0);
    rng_next = {rng_q[WIDTH-2:0], fb};
  end

  // Offset-binary tap vs shared random value, one comparator per tap
  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      raw[i] = (taps_flat[i*WIDTH +: WIDTH] ^ OFFSET) > rng_q;
    end
  end

  // Window sequencing; en is only looked at on window boundaries
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rng_d   = rng_q;
    if (state_q == IDLE) begin
      if (en) begin
        state_d = RUN;
        cnt_d   = '0;
        rng_d   = LFSR_SEED;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      rng_d = rng_next;
      if (cnt_q == CNT_MAX && !en) begin
        state_d = IDLE;
      end
    end
  end

  // Registered outputs; advance is pre-decoded so it coincides with cnt == max
  always_comb begin
    adv_d    = (state_d == RUN) && (cnt_d == CNT_MAX);
    valid_d  = (state_q == RUN);
    last_d   = (state_q == RUN) && (cnt_q == CNT_MAX);
    stream_d = (state_q == RUN) ? raw : stream_q;
  end

  // State and output flops, asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rng_q    <= LFSR_SEED;
      adv_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      stream_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rng_q    <= rng_d;
      adv_q    <= adv_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      stream_q <= stream_d;
    end
  end

  assign sample_advance = adv_q;
  assign stream_out     = stream_q;
  assign stream_valid   = valid_q;
  assign window_last    = last_q;
  assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_sc_stream_gen.sv
// Directed testbench for sc_stream_gen: encoding exactness, pacing,
// graceful stop, mid-window reset and an end-to-end delay-line model.
module tb_sc_stream_gen;

  localparam int NTAPS = 152;
  localparam int W     = 8;

  logic                 clk;
  logic                 reset;
  logic                 en;
  logic [NTAPS*W-1:0]   taps_flat;
  logic                 sample_advance;
  logic [NTAPS-1:0]     stream_out;
  logic                 stream_valid;
  logic                 window_last;
  logic                 busy;

  logic [NTAPS*W-1:0]   tb_taps;
  logic [NTAPS*W-1:0]   dl_taps;
  logic                 dl_mode;
  logic [W-1:0]         dl_in;
  logic [W-1:0]         dl_queue [$];

  logic [W-1:0]         rngseq [256];
  int                   win_cnt [4][6];
  int                   checks;
  int                   failures;

  sc_stream_gen #(
    .NTAPS     (NTAPS),
    .WIDTH     (W),
    .LFSR_POLY (8'hB8),
    .LFSR_SEED (8'h01)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .taps_flat      (taps_flat),
    .sample_advance (sample_advance),
    .stream_out     (stream_out),
    .stream_valid   (stream_valid),
    .window_last    (window_last),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delay line model: shifts a new sample into tap 0 on each advance
  always @(posedge clk or posedge reset) begin
    if (reset) dl_taps <= '0;
    else if (sample_advance) dl_taps <= {dl_taps[NTAPS*W-W-1:0], dl_in};
  end

  assign taps_flat = dl_mode ? dl_taps : tb_taps;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [NTAPS-1:0] obs, input logic [NTAPS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NTAPS-1:0] exp_bits(input logic [NTAPS*W-1:0] t, input logic [W-1:0] r);
    logic [NTAPS-1:0] b;
    logic [W-1:0] tap;
    for (int i = 0; i < NTAPS; i++) begin
      tap  = t[i*W +: W];
      b[i] = (tap ^ 8'h80) > r;
    end
    return b;
  endfunction

  // Starts at a negedge with the DUT idle, raises en, checks every cycle.
  // drop_at < 0 keeps en high; otherwise en falls after cycle drop_at.
  task automatic run(input int ncyc, input int drop_at);
    logic [NTAPS*W-1:0] prev;
    logic [NTAPS-1:0]   held;
    int                 last_run;
    int                 ones [6];
    int                 w;
    logic               in_run;
    last_run = (drop_at < 0) ? 32'h3fff_ffff : (drop_at / 256) * 256 + 255;
    foreach (win_cnt[a, b]) win_cnt[a][b] = -1;
    foreach (ones[i]) ones[i] = 0;
    w    = 0;
    held = '0;
    prev = taps_flat;
    en   = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      in_run = (c <= last_run);
      chk("busy", busy, in_run);
      chk("sample_advance", sample_advance, in_run && (c % 256 == 255));
      chk("window_last", window_last, (c > 0) && (c % 256 == 0) && (c <= last_run + 1));
      chk("stream_valid", stream_valid, (c >= 1) && (c <= last_run + 1));
      if (c >= 1 && c <= last_run + 1) begin
        held = exp_bits(prev, rngseq[(c - 1) % 256]);
        chk("stream_out", stream_out, held);
        for (int i = 0; i < 6; i++) ones[i] += int'(stream_out[i]);
        if (c % 256 == 0) begin
          if (w < 4) win_cnt[w] = ones;
          w++;
          foreach (ones[i]) ones[i] = 0;
          if (dl_queue.size() > 0) dl_in = dl_queue.pop_front();
        end
      end else if (c > last_run + 1) begin
        chk("stream_hold", stream_out, held);
      end
      prev = taps_flat;
      if (c == drop_at) en = 1'b0;
    end
  endtask

  task automatic chk_enc(input int w);
    chk("cnt_tap0_m128", NTAPS'(win_cnt[w][0]), NTAPS'(0));
    chk("cnt_tap1_m1",   NTAPS'(win_cnt[w][1]), NTAPS'(127));
    chk("cnt_tap2_0",    NTAPS'(win_cnt[w][2]), NTAPS'(128));
    chk("cnt_tap3_64",   NTAPS'(win_cnt[w][3]), NTAPS'(192));
    chk("cnt_tap4_127",  NTAPS'(win_cnt[w][4]), NTAPS'(255));
    chk("cnt_tap5_rest", NTAPS'(win_cnt[w][5]), NTAPS'(128));
  endtask

  initial begin
    logic [W-1:0] r;
    logic         fb;
    logic         adv_seen;
    logic         busy_seen;
    checks   = 0;
    failures = 0;
    r = 8'h01;
    for (int k = 0; k < 256; k++) begin
      rngseq[k] = r;
      fb = (^(r & 8'hB8)) ^ (r[6:0] == 7'd0);
      r  = {r[6:0], fb};
    end

    reset   = 1'b1;
    en      = 1'b0;
    dl_mode = 1'b0;
    dl_in   = '0;
    tb_taps = '0;
    tb_taps[0*W +: W] = 8'h80;
    tb_taps[1*W +: W] = 8'hFF;
    tb_taps[2*W +: W] = 8'h00;
    tb_taps[3*W +: W] = 8'h40;
    tb_taps[4*W +: W] = 8'h7F;

    repeat (3) @(negedge clk);
    chk("rst_sample_advance", sample_advance, 1'b0);
    chk("rst_stream_out", stream_out, '0);
    chk("rst_stream_valid", stream_valid, 1'b0);
    chk("rst_window_last", window_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", stream_valid, 1'b0);

    // Three full windows, then drop en at cnt=100 of the fourth
    run(4 * 256 + 4, 3 * 256 + 100);
    for (int w = 0; w < 4; w++) chk_enc(w);

    // Reset at cnt=50: outputs clear at once, no advance follows
    run(51, -1);
    reset = 1'b1;
    en    = 1'b0;
    #1;
    chk("midrst_sample_advance", sample_advance, 1'b0);
    chk("midrst_stream_out", stream_out, '0);
    chk("midrst_stream_valid", stream_valid, 1'b0);
    chk("midrst_window_last", window_last, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    adv_seen  = 1'b0;
    busy_seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 2) reset = 1'b0;
      adv_seen  = adv_seen | sample_advance;
      busy_seen = busy_seen | busy;
    end
    chk("midrst_no_advance", adv_seen, 1'b0);
    chk("midrst_stays_idle", busy_seen, 1'b0);
    run(256 + 3, 255);
    chk_enc(0);

    // End-to-end with the delay line model
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    dl_mode = 1'b1;
    dl_in   = 8'h40;
    dl_queue.push_back(8'hC0);
    @(negedge clk);
    run(3 * 256 + 3, 2 * 256 + 255);
    chk("e2e_w0_tap0", NTAPS'(win_cnt[0][0]), NTAPS'(128));
    chk("e2e_w1_tap0", NTAPS'(win_cnt[1][0]), NTAPS'(192));
    chk("e2e_w1_tap1", NTAPS'(win_cnt[1][1]), NTAPS'(128));
    chk("e2e_w2_tap0", NTAPS'(win_cnt[2][0]), NTAPS'(64));
    chk("e2e_w2_tap1", NTAPS'(win_cnt[2][1]), NTAPS'(192));
    chk("e2e_w2_tap2", NTAPS'(win_cnt[2][2]), NTAPS'(128));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
